// File: rtl/ym3438_pkg.sv
// ============================================================================
// Module   : ym3438_pkg
// Purpose  : Shared constants, FSM state type and sample decode for the
//            YM3438 channel mixer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ym3438_pkg;

    localparam int C_NUM_CH = 6;
    localparam int C_PAN_L  = 1;
    localparam int C_PAN_R  = 0;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_ACCUM     = 2'd1,
        ST_EXPECT    = 2'd2
    } mixer_state_t;

    // Channel samples arrive offset binary; flipping the MSB yields two's complement.
    function automatic logic signed [8:0] decode_sample(input logic [8:0] raw);
        return $signed({~raw[8], raw[7:0]});
    endfunction

endpackage

`default_nettype wire

// File: rtl/ym3438_ch_mixer_acc.sv
// ============================================================================
// Module   : ym3438_ch_mixer_acc
// Purpose  : One signed frame accumulator with load / clear / add controls.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ym3438_ch_mixer_acc #(
    parameter int ACC_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_clear,
    input  logic                    i_add,
    input  logic signed [ACC_W-1:0] i_din,
    output logic signed [ACC_W-1:0] o_sum
);

    logic signed [ACC_W-1:0] r_acc;

    // o_sum is what an add would store; the top samples it on the last slot.
    assign o_sum = r_acc + i_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_din;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= o_sum;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ym3438_ch_mixer.sv
// ============================================================================
// Module   : ym3438_ch_mixer
// Purpose  : Accumulates NUM_CH time-multiplexed channel samples into one
//            stereo frame and presents it through a valid/ready handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ym3438_ch_mixer
    import ym3438_pkg::*;
#(
    parameter int NUM_CH = C_NUM_CH,
    parameter int ACC_W  = 12,
    parameter int OUT_W  = 16
) (
    input  logic                    MCLK,
    input  logic                    reset,
    input  logic                    slot_en,
    input  logic                    frame_sync,
    input  logic [8:0]              ch_out,
    input  logic [1:0]              ch_pan,
    output logic signed [OUT_W-1:0] out_l,
    output logic signed [OUT_W-1:0] out_r,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sync_err,
    output logic [7:0]              drop_cnt
);

    localparam int              C_SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int              C_SHIFT  = OUT_W - ACC_W;
    localparam logic [C_SLOT_W-1:0] C_LAST = C_SLOT_W'(NUM_CH - 1);

    mixer_state_t            r_state, w_state_next;
    logic [C_SLOT_W-1:0]     r_slot, w_slot_next;
    logic                    w_load, w_add, w_clear, w_done, w_err_set;
    logic signed [8:0]       w_s;
    logic signed [ACC_W-1:0] w_s_ext, w_con_l, w_con_r;
    logic signed [ACC_W-1:0] w_sum_l, w_sum_r;
    logic signed [OUT_W-1:0] w_ext_l, w_ext_r;

    assign w_s     = decode_sample(ch_out);
    assign w_s_ext = ACC_W'(w_s);
    assign w_con_l = ch_pan[C_PAN_L] ? w_s_ext : '0;
    assign w_con_r = ch_pan[C_PAN_R] ? w_s_ext : '0;

    ym3438_ch_mixer_acc #(.ACC_W(ACC_W)) u_acc_l (
        .clk     (MCLK),
        .rst     (reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_add   (w_add),
        .i_din   (w_con_l),
        .o_sum   (w_sum_l)
    );

    ym3438_ch_mixer_acc #(.ACC_W(ACC_W)) u_acc_r (
        .clk     (MCLK),
        .rst     (reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_add   (w_add),
        .i_din   (w_con_r),
        .o_sum   (w_sum_r)
    );

    assign w_ext_l = OUT_W'(w_sum_l);
    assign w_ext_r = OUT_W'(w_sum_r);

    // ST_EXPECT is the post-frame state: a missing sync there flywheels
    // instead of being ignored as it is before the first sync.
    always_comb begin
        w_state_next = r_state;
        w_slot_next  = r_slot;
        w_load       = 1'b0;
        w_add        = 1'b0;
        w_clear      = 1'b0;
        w_done       = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_WAIT_SYNC: begin
                if (slot_en && frame_sync) begin
                    w_load       = 1'b1;
                    w_slot_next  = C_SLOT_W'(1);
                    w_state_next = ST_ACCUM;
                end
            end
            ST_EXPECT: begin
                if (slot_en) begin
                    w_load       = 1'b1;
                    w_err_set    = !frame_sync;
                    w_slot_next  = C_SLOT_W'(1);
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (slot_en && frame_sync) begin
                    w_load      = 1'b1;
                    w_err_set   = 1'b1;
                    w_slot_next = C_SLOT_W'(1);
                end else if (slot_en && (r_slot == C_LAST)) begin
                    w_done       = 1'b1;
                    w_clear      = 1'b1;
                    w_slot_next  = '0;
                    w_state_next = ST_EXPECT;
                end else if (slot_en) begin
                    w_add       = 1'b1;
                    w_slot_next = r_slot + C_SLOT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_WAIT_SYNC;
                w_slot_next  = '0;
            end
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_state  <= ST_WAIT_SYNC;
            r_slot   <= '0;
            sync_err <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_slot   <= w_slot_next;
            sync_err <= sync_err | w_err_set;
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            drop_cnt  <= '0;
        end else if (w_done) begin
            out_l     <= w_ext_l <<< C_SHIFT;
            out_r     <= w_ext_r <<< C_SHIFT;
            out_valid <= 1'b1;
            if (out_valid && !out_ready && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ym3438_ch_mixer.sv
// ============================================================================
// Module   : tb_ym3438_ch_mixer
// Purpose  : Directed self-checking bench for ym3438_ch_mixer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ym3438_ch_mixer;

    logic               MCLK = 1'b0;
    logic               reset;
    logic               slot_en;
    logic               frame_sync;
    logic [8:0]         ch_out;
    logic [1:0]         ch_pan;
    logic signed [15:0] out_l;
    logic signed [15:0] out_r;
    logic               out_valid;
    logic               out_ready;
    logic               sync_err;
    logic [7:0]         drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ym3438_ch_mixer #(.NUM_CH(6), .ACC_W(12), .OUT_W(16)) dut (
        .MCLK       (MCLK),
        .reset      (reset),
        .slot_en    (slot_en),
        .frame_sync (frame_sync),
        .ch_out     (ch_out),
        .ch_pan     (ch_pan),
        .out_l      (out_l),
        .out_r      (out_r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sync_err   (sync_err),
        .drop_cnt   (drop_cnt)
    );

    always #5 MCLK = ~MCLK;

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the falling edge.
    task automatic do_slot(input logic fs, input logic [8:0] d, input logic [1:0] p);
        slot_en    = 1'b1;
        frame_sync = fs;
        ch_out     = d;
        ch_pan     = p;
        @(negedge MCLK);
        slot_en    = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic send_frame(input logic fs0, input logic [8:0] d, input logic [1:0] p);
        for (int i = 0; i < 6; i++) begin
            do_slot((i == 0) ? fs0 : 1'b0, d, p);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge MCLK);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge MCLK);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; slot_en = 1'b0; frame_sync = 1'b0;
        ch_out = 9'h100; ch_pan = 2'b00; out_ready = 1'b0;
        idle(3);
        reset = 1'b0;
        check_value("rst_out_l", out_l, 16'h0000);
        check_value("rst_out_r", out_r, 16'h0000);
        check_value("rst_valid", {15'd0, out_valid}, 16'd0);
        check_value("rst_sync_err", {15'd0, sync_err}, 16'd0);
        check_value("rst_drop", {8'd0, drop_cnt}, 16'd0);

        // Unsynchronised slots are ignored, then reset lands on slot 4.
        for (int i = 0; i < 3; i++) do_slot(1'b0, 9'h17F, 2'b11);
        check_value("presync_valid", {15'd0, out_valid}, 16'd0);
        check_value("presync_err", {15'd0, sync_err}, 16'd0);
        send_frame(1'b1, 9'h17F, 2'b11);
        accept();
        check_value("presync_frame_l", out_l, 16'h2FA0);
        for (int i = 0; i < 4; i++) do_slot(i == 0, 9'h17F, 2'b11);
        reset = 1'b1; slot_en = 1'b1; ch_out = 9'h17F; ch_pan = 2'b11;
        @(negedge MCLK);
        reset = 1'b0; slot_en = 1'b0;
        check_value("midrst_valid", {15'd0, out_valid}, 16'd0);
        check_value("midrst_out_l", out_l, 16'h0000);
        check_value("midrst_out_r", out_r, 16'h0000);
        do_slot(1'b0, 9'h17F, 2'b11);
        idle(2);
        check_value("midrst_ignore", {15'd0, out_valid}, 16'd0);

        // All channels +127 on both sides.
        send_frame(1'b1, 9'h17F, 2'b11);
        check_value("t1_out_l", out_l, 16'h2FA0);
        check_value("t1_out_r", out_r, 16'h2FA0);
        check_value("t1_valid", {15'd0, out_valid}, 16'd1);
        idle(3);
        check_value("t1_hold_l", out_l, 16'h2FA0);
        accept();
        check_value("t1_accept", {15'd0, out_valid}, 16'd0);

        // Split panning, negative left.
        for (int i = 0; i < 6; i++) begin
            if (i < 3) do_slot(i == 0, 9'h080, 2'b10);
            else       do_slot(1'b0, 9'h17F, 2'b01);
        end
        check_value("t2_out_l", out_l, 16'hE800);
        check_value("t2_out_r", out_r, 16'h17D0);
        accept();

        // Early sync on slot 3 restarts the frame.
        for (int i = 0; i < 3; i++) do_slot(i == 0, 9'h17F, 2'b11);
        do_slot(1'b1, 9'h101, 2'b11);
        check_value("t3_err", {15'd0, sync_err}, 16'd1);
        check_value("t3_nooutput", {15'd0, out_valid}, 16'd0);
        for (int i = 0; i < 5; i++) do_slot(1'b0, 9'h101, 2'b11);
        check_value("t3_out_l", out_l, 16'h0060);
        check_value("t3_out_r", out_r, 16'h0060);
        accept();

        // Missing sync after a completed frame flywheels as channel 0.
        send_frame(1'b0, 9'h102, 2'b10);
        check_value("fly_valid", {15'd0, out_valid}, 16'd1);
        check_value("fly_out_l", out_l, 16'h00C0);
        check_value("fly_out_r", out_r, 16'h0000);
        check_value("fly_err_sticky", {15'd0, sync_err}, 16'd1);
        accept();

        // Three frames with no consumer: two drops.
        send_frame(1'b1, 9'h101, 2'b11);
        send_frame(1'b1, 9'h102, 2'b11);
        send_frame(1'b1, 9'h103, 2'b11);
        check_value("t4_drop", {8'd0, drop_cnt}, 16'd2);
        check_value("t4_out_l", out_l, 16'h0120);
        check_value("t4_valid", {15'd0, out_valid}, 16'd1);
        accept();
        check_value("t4_accept", {15'd0, out_valid}, 16'd0);

        // Frame completes in the same cycle the pending one is accepted.
        send_frame(1'b1, 9'h17F, 2'b11);
        for (int i = 0; i < 5; i++) do_slot(i == 0, 9'h0FF, 2'b01);
        out_ready = 1'b1;
        do_slot(1'b0, 9'h0FF, 2'b01);
        out_ready = 1'b0;
        check_value("t5_valid", {15'd0, out_valid}, 16'd1);
        check_value("t5_out_l", out_l, 16'h0000);
        check_value("t5_out_r", out_r, 16'hFFA0);
        check_value("t5_drop", {8'd0, drop_cnt}, 16'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ym3438_ch_mixer.md
Name: ym3438_ch_mixer

Overview:
- Receiver end of the per-channel output stream produced by the channel accumulator/DAC block.
- Consumes the time-multiplexed 9-bit channel sample and 2-bit pan, one channel per slot strobe.
- Decodes the offset-binary sample and accumulates left and right sums over one frame of NUM_CH slots.
- Presents one stereo PCM sample per frame through a valid/ready handshake, for the audio output path and the testbench.

Parameters:
NUM_CH, 6, channel slots per frame
ACC_W, 12, signed accumulator width; must satisfy NUM_CH*256 <= 2^(ACC_W-1)
OUT_W, 16, output sample width; output = accumulator << (OUT_W-ACC_W)

Ports:
MCLK  in  1  system clock
reset  in  1  synchronous active-high reset
slot_en  in  1  one-cycle strobe: ch_out/ch_pan valid for the current channel slot
frame_sync  in  1  qualified by slot_en: this slot is channel 0 of a new frame
ch_out  in  9  channel sample, offset binary (MSB inverted two's complement)
ch_pan  in  2  [1]=left enable, [0]=right enable
out_l  out  OUT_W  left sample, signed
out_r  out  OUT_W  right sample, signed
out_valid  out  1  out_l/out_r hold an unconsumed frame
out_ready  in  1  consumer accepts when out_valid&&out_ready
sync_err  out  1  sticky framing error flag
drop_cnt  out  8  saturating count of frames overwritten before acceptance

Behaviour:
- Interface: one clock, MCLK; reset is synchronous and active-high.
- Reset: state=WAIT_SYNC, slot=0, acc_l=acc_r=0, out_l=out_r=0, out_valid=0, sync_err=0, drop_cnt=0.
- Reset asserted mid-frame discards the partial frame and any pending output.
- Decode: s = {~ch_out[8], ch_out[7:0]} as signed 9-bit.
  - Examples: 9'h17F -> +127; 9'h080 -> -128; 9'h100 -> 0.
  - Sign-extend s to ACC_W.
  - Left contribution = ch_pan[1] ? s : 0. Right contribution = ch_pan[0] ? s : 0.
- FSM states:
  - WAIT_SYNC: slot_en without frame_sync is ignored. slot_en&&frame_sync loads acc_l/acc_r with the slot-0 contributions, sets slot=1, goes to ACCUM.
  - ACCUM: slot_en&&!frame_sync adds the contributions and increments slot.
- Frame completion:
  - The slot_en at slot==NUM_CH-1 completes the frame.
  - The completed sums are written to out_l/out_r the next cycle with out_valid=1, so latency is 1 cycle after the final slot_en.
  - FSM returns to WAIT_SYNC-equivalent expectancy: the next slot_en must carry frame_sync.
- Early frame_sync (slot_en&&frame_sync with 0<slot<NUM_CH in ACCUM):
  - Set sync_err.
  - Discard the partial sums; no output.
  - Restart the frame with this slot as channel 0.
- Missing frame_sync (slot_en&&!frame_sync when a new frame is expected after completion):
  - Set sync_err.
  - Treat the slot as channel 0 anyway (flywheel).
- sync_err clears only on reset.
- Accumulation does not overflow by the ACC_W constraint; no saturation logic.
- Output handshake:
  - out_valid&&out_ready: clears out_valid, unless a new frame loads in the same cycle, in which case out_valid stays 1 with new data and there is no drop.
  - New frame loads while out_valid&&!out_ready: data is overwritten and drop_cnt increments, saturating at 255.
  - out_l/out_r are stable while out_valid=1 and no new frame loads.
- slot_en is at most one per cycle. Back-to-back slot_en cycles are legal.

Decomposition:
- Shared package ym3438_pkg: NUM_CH default, decode function (offset binary to signed), pan bit index constants L=1, R=0.
- One natural sub-module: ym3438_ch_mixer_acc, one signed accumulator with load/add/clear, instantiated twice (left and right).
- FSM, slot counter and output buffer stay in the top module.

Test Plan:
- Reset, then 6 slots with frame_sync on slot 0, every ch_out=9'h17F, ch_pan=2'b11 -> one cycle after the 6th slot_en, out_l=out_r=16'h2FA0 (762<<4), out_valid=1.
- Frame of ch_out=9'h080 on slots 0-2 with pan=2'b10, and 9'h17F on slots 3-5 with pan=2'b01 -> out_l=-384<<4=16'hE800, out_r=381<<4=16'h17D0.
- frame_sync asserted at slot 3 -> sync_err=1, no output for the partial frame; the following 6 slots of 9'h101 (+1), pan=11 -> out_l=out_r=16'h0060.
- out_ready held 0 across 3 completed frames -> drop_cnt=2, out_l holds the third frame. Then out_ready=1 -> out_valid drops the next cycle.
- Frame completes in the same cycle out_ready=1 with out_valid=1 -> out_valid stays 1, new data presented, drop_cnt unchanged.
- Slot strobes before the first frame_sync, plus reset asserted at slot 4 -> slots ignored, all outputs 0, out_valid=0, next frame_sync frame accumulates cleanly.
